rv_instr_encoder: RTL and testbench

Streaming RV64IM instruction encoder: the inverse of the instruction decoder, turning format-tagged field bundles back into 32-bit instruction words. It packs two instructions per 64-bit fetch word, so its output feeds the same 64-bit instruction path the decoder consumes. Its users are the test-program generator and the instruction-memory preload path. It range-checks every immediate, drops illegal bundles, and counts them.

---
 rtl/rv_instr_encoder_if.sv | 35 +++
 rtl/rv_instr_encoder.sv | 164 ++++++++++++++++
 tb/tb_rv_instr_encoder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_instr_encoder_if.sv
// Bundle-in / packed-word-out interface of the RV64IM instruction encoder.
// The master side produces field bundles and consumes 64-bit fetch words.
interface rv_instr_encoder_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_fmt;
  logic [6:0]           in_opcode;
  logic [2:0]           in_funct3;
  logic [6:0]           in_funct7;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [31:0]          in_imm;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_data;
  logic                 half_pending;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, flush, out_ready,
    input  in_ready, out_valid, out_data, half_pending, err, err_count
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, flush, out_ready,
    output in_ready, out_valid, out_data, half_pending, err, err_count
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Streaming RV64IM encoder: format-tagged field bundles become 32-bit words,
// packed two per 64-bit fetch word (older instruction in the low half).
module rv_instr_encoder #(
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
  parameter int          ERR_CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  rv_instr_encoder_if.slave bus
);

  // True when v is a sign extension of its bits [sign_bit:0].
  function automatic logic imm_fits(input logic [31:0] v, input int unsigned sign_bit);
    logic [31:0] hi;
    hi = $signed(v) >>> sign_bit;
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

  logic [31:0]          word_s;
  logic                 imm_ok_s;
  logic                 legal_s;
  logic                 accept_s;
  logic                 slot_free_s;
  logic                 flush_req_s;

  logic [31:0]          half_q, half_d;
  logic                 half_pending_q, half_pending_d;
  logic [63:0]          out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [31:0] imm_s;
  assign imm_s = bus.in_imm;

  // Field placement and immediate range check for each format.
  always_comb begin
    word_s   = 32'h0000_0000;
    imm_ok_s = 1'b0;
    case (bus.in_fmt)
      3'd0: begin
        word_s   = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        imm_ok_s = 1'b1;
      end
      3'd1: begin
        word_s   = {imm_s[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        imm_ok_s = imm_fits(imm_s, 11);
      end
      3'd2: begin
        word_s   = {imm_s[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm_s[4:0], bus.in_opcode};
        imm_ok_s = imm_fits(imm_s, 11);
      end
      3'd3: begin
        word_s   = {imm_s[12], imm_s[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    imm_s[4:1], imm_s[11], bus.in_opcode};
        imm_ok_s = imm_fits(imm_s, 12) && !imm_s[0];
      end
      3'd4: begin
        word_s   = {imm_s[31:12], bus.in_rd, bus.in_opcode};
        imm_ok_s = (imm_s[11:0] == 12'h000);
      end
      3'd5: begin
        word_s   = {imm_s[20], imm_s[10:1], imm_s[11], imm_s[19:12], bus.in_rd, bus.in_opcode};
        imm_ok_s = imm_fits(imm_s, 20) && !imm_s[0];
      end
      default: begin
        word_s   = 32'h0000_0000;
        imm_ok_s = 1'b0;
      end
    endcase
  end

  assign legal_s     = imm_ok_s && (bus.in_opcode[1:0] == 2'b11);
  assign slot_free_s = !out_valid_q || bus.out_ready;
  // A pending half may only complete into a free output slot.
  assign bus.in_ready = !half_pending_q || slot_free_s;
  assign accept_s    = bus.in_valid && bus.in_ready;
  assign flush_req_s = bus.flush || flush_pend_q;

  // Packer, flush and error-counter next state.
  always_comb begin
    half_d         = half_q;
    half_pending_d = half_pending_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q && !bus.out_ready;
    flush_pend_d   = flush_pend_q;
    err_d          = 1'b0;
    err_count_d    = err_count_q;

    if (accept_s && !legal_s) begin
      err_d = 1'b1;
      if (err_count_q != {ERR_CNT_W{1'b1}}) begin
        err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      err_count_d = err_count_q;
    end

    if (accept_s && legal_s) begin
      if (half_pending_q) begin
        out_data_d     = {word_s, half_q};
        out_valid_d    = 1'b1;
        half_pending_d = 1'b0;
        flush_pend_d   = 1'b0;
      end else if (flush_req_s && slot_free_s) begin
        out_data_d   = {NOP_WORD, word_s};
        out_valid_d  = 1'b1;
        flush_pend_d = 1'b0;
      end else if (flush_req_s) begin
        // Slot busy: park the word and pad it once the slot frees.
        half_d         = word_s;
        half_pending_d = 1'b1;
        flush_pend_d   = 1'b1;
      end else begin
        half_d         = word_s;
        half_pending_d = 1'b1;
      end
    end else if (flush_req_s) begin
      if (!half_pending_q) begin
        flush_pend_d = 1'b0;
      end else if (slot_free_s) begin
        out_data_d     = {NOP_WORD, half_q};
        out_valid_d    = 1'b1;
        half_pending_d = 1'b0;
        flush_pend_d   = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end else begin
      flush_pend_d = flush_pend_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      half_q         <= 32'h0000_0000;
      half_pending_q <= 1'b0;
      out_data_q     <= 64'h0;
      out_valid_q    <= 1'b0;
      flush_pend_q   <= 1'b0;
      err_q          <= 1'b0;
      err_count_q    <= {ERR_CNT_W{1'b0}};
    end else begin
      half_q         <= half_d;
      half_pending_q <= half_pending_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      flush_pend_q   <= flush_pend_d;
      err_q          <= err_d;
      err_count_q    <= err_count_d;
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.half_pending = half_pending_q;
  assign bus.err          = err_q;
  assign bus.err_count    = err_count_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Self-checking bench for rv_instr_encoder: vector table plus scoreboard of
// expected 64-bit words, with hand-written stall, flush and reset sequences.
module tb_rv_instr_encoder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
    logic        bad;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rv_instr_encoder_if #(.ERR_CNT_W(8)) bus ();

  rv_instr_encoder #(.NOP_WORD(NOP), .ERR_CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_half;
  logic        m_pend;
  logic [7:0]  exp_errcnt;
  logic        mon_en = 1'b0;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic [31:0] word, input logic bad);
    vec_t v;
    v.fmt = fmt; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.word = word; v.bad = bad;
    return v;
  endfunction

  // Reference packer: expected words queued as soon as they are determined.
  task automatic model_legal(input logic [31:0] w, input logic fl);
    if (m_pend) begin
      exp_q.push_back({w, m_half});
      m_pend = 1'b0;
    end else if (fl) begin
      exp_q.push_back({NOP, w});
    end else begin
      m_half = w;
      m_pend = 1'b1;
    end
  endtask

  task automatic model_flush();
    if (m_pend) begin
      exp_q.push_back({NOP, m_half});
      m_pend = 1'b0;
    end
  endtask

  task automatic send(input vec_t v, input logic fl);
    int budget;
    @(negedge clk);
    bus.in_fmt = v.fmt; bus.in_opcode = v.op; bus.in_funct3 = v.f3; bus.in_funct7 = v.f7;
    bus.in_rd = v.rd; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2; bus.in_imm = v.imm;
    bus.in_valid = 1'b1;
    budget = 0;
    while (!bus.in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
    end else begin
      bus.flush = fl;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      if (v.bad) begin
        if (exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'd1;
        if (fl) model_flush();
      end else begin
        model_legal(v.word, fl);
      end
      chk("err_pulse", 64'(bus.err), 64'(v.bad));
      chk("err_count", 64'(bus.err_count), 64'(exp_errcnt));
      chk("half_pending", 64'(bus.half_pending), 64'(m_pend));
    end
  endtask

  task automatic send_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    model_flush();
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1;
    bus.out_ready = r;
  endtask

  // Scoreboard: every handshaken output word must match the next expected one.
  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", bus.out_data);
      end else begin
        chk("out_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  vec_t v_add, v_addi, v_sw, v_beq, v_lui, v_jal, v_bad7;

  initial begin
    v_add  = mkv(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h0020_81B3, 1'b0);
    v_addi = mkv(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0005, 32'h0050_0093, 1'b0);
    v_sw   = mkv(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0);
    v_beq  = mkv(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_8463, 1'b0);
    v_lui  = mkv(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    v_jal  = mkv(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    v_bad7 = mkv(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0000, 32'h0000_0000, 1'b1);

    tbl.push_back(mkv(3'd0, 7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 32'h0000_0000, 32'h4073_02B3, 1'b0));
    tbl.push_back(mkv(3'd0, 7'h31, 3'd0, 7'h00, 5'd5, 5'd6, 5'd7, 32'h0000_0000, 32'h0000_0000, 1'b1));
    tbl.push_back(mkv(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0, 32'hFFFF_F800, 32'h8000_8093, 1'b0));
    tbl.push_back(mkv(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'h0000_07FF, 32'h7FF0_0113, 1'b0));
    tbl.push_back(mkv(3'd2, 7'h23, 3'd0, 7'h00, 5'd0, 5'd6, 5'd5, 32'hFFFF_F7FF, 32'h0000_0000, 1'b1));
    tbl.push_back(mkv(3'd3, 7'h63, 3'd1, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000, 32'h8020_9063, 1'b0));
    tbl.push_back(mkv(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0FFE, 32'h7E20_8FE3, 1'b0));
    tbl.push_back(mkv(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_1000, 32'h0000_0000, 1'b1));
    tbl.push_back(mkv(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 32'h8000_006F, 1'b0));
    tbl.push_back(mkv(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0010_0000, 32'h0000_0000, 1'b1));
    tbl.push_back(mkv(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0003, 32'h0000_0000, 1'b1));
    tbl.push_back(mkv(3'd4, 7'h17, 3'd0, 7'h00, 5'd10, 5'd0, 5'd0, 32'hFFFF_F000, 32'hFFFF_F517, 1'b0));
    tbl.push_back(mkv(3'd6, 7'h33, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'h0000_0000, 32'h0000_0000, 1'b1));
    tbl.push_back(mkv(3'd4, 7'h37, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0000_0000, 1'b1));
    tbl.push_back(mkv(3'd2, 7'h23, 3'd0, 7'h00, 5'd0, 5'd6, 5'd5, 32'h0000_07FF, 32'h7E53_0FA3, 1'b0));
    tbl.push_back(mkv(3'd0, 7'h33, 3'd0, 7'h01, 5'd4, 5'd5, 5'd6, 32'h0000_0000, 32'h0262_8233, 1'b0));

    bus.in_valid = 1'b0; bus.in_fmt = 3'd0; bus.in_opcode = 7'h00; bus.in_funct3 = 3'd0;
    bus.in_funct7 = 7'h00; bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
    bus.in_imm = 32'h0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    m_half = 32'h0; m_pend = 1'b0; exp_errcnt = 8'd0;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_half_pending", 64'(bus.half_pending), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    send(v_add, 1'b0);
    send(v_addi, 1'b0);
    chk("pair_latency_valid", 64'(bus.out_valid), 64'd1);
    chk("pair_latency_data", bus.out_data, 64'h0050_0093_0020_81B3);
    send(v_sw, 1'b0);
    send(v_beq, 1'b0);
    chk("sw_beq_data", bus.out_data, 64'h0020_8463_FE20_AE23);
    send(v_lui, 1'b0);
    send_flush();
    chk("flush_latency_data", bus.out_data, 64'h0000_0013_1234_52B7);
    send(v_jal, 1'b1);
    chk("jal_flush_data", bus.out_data, 64'h0000_0013_0010_00EF);

    send(mkv(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0, 1'b1), 1'b0);
    send(mkv(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0007, 32'h0, 1'b1), 1'b0);
    send(mkv(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0, 1'b1), 1'b0);
    send(v_bad7, 1'b0);
    @(negedge clk);
    chk("illegal_count4", 64'(bus.err_count), 64'd4);
    chk("illegal_no_output", 64'(bus.out_valid), 64'd0);

    foreach (tbl[i]) send(tbl[i], 1'b0);
    send_flush();

    // Stall: the held word stays put and the third accept closes in_ready.
    set_ready(1'b0);
    send(v_add, 1'b0);
    send(v_addi, 1'b0);
    send(v_sw, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_hold_data", bus.out_data, 64'h0050_0093_0020_81B3);
    end
    fork
      begin
        send(v_beq, 1'b0);
        send(v_lui, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    send_flush();

    // Flush while the slot is blocked must wait, then pad.
    set_ready(1'b0);
    send(v_add, 1'b0);
    send(v_addi, 1'b0);
    send(v_jal, 1'b0);
    send_flush();
    chk("flush_pend_half_kept", 64'(bus.half_pending), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("flush_pend_hold_data", bus.out_data, 64'h0050_0093_0020_81B3);
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("flush_pend_drained", 64'(bus.half_pending), 64'd0);

    repeat (260) send(v_bad7, 1'b0);
    chk("err_count_saturated", 64'(bus.err_count), 64'hFF);

    // Reset with a held output word and a pending half.
    set_ready(1'b0);
    send(v_add, 1'b0);
    send(v_addi, 1'b0);
    send(v_sw, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_data", bus.out_data, 64'd0);
    chk("mid_rst_half_pending", 64'(bus.half_pending), 64'd0);
    chk("mid_rst_err_count", 64'(bus.err_count), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    m_pend = 1'b0;
    exp_errcnt = 8'd0;
    @(negedge clk);
    reset_n = 1'b1;
    set_ready(1'b1);
    send(v_add, 1'b0);
    send(v_addi, 1'b0);
    chk("post_rst_pair", bus.out_data, 64'h0050_0093_0020_81B3);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
